// File: rtl/mem_arbiter.sv
// mem_arbiter
// ---------------------------------------------------------------------------
// Two-client arbiter that shares one line-wide memory port between an
// instruction cache (read only) and a data cache (read or write).
//
// A request seen in IDLE is latched (owner, address, write enable, write
// line) and presented to memory from BUSY. The memory completion strobe is
// forwarded to the owner in the same cycle. A one-cycle RELEASE gap follows,
// so a requester still holding its request right after its response is not
// granted again.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   i_req_i          icache line-read request, held until i_valid_o
//   i_addr_i         icache line address
//   i_valid_o        icache response strobe
//   i_data_o         icache read line (zero unless i_valid_o)
//   d_req_i          dcache request, held until d_valid_o
//   d_we_i           dcache write (1) / read (0)
//   d_addr_i         dcache line address
//   d_wdata_i        dcache write line
//   d_valid_o        dcache response strobe (read data or write ack)
//   d_data_o         dcache read line (zero unless d_valid_o)
//   mem_req_o        memory request, high for the whole of BUSY
//   mem_we_o         memory write enable
//   mem_addr_o       memory address
//   mem_wdata_o      memory write line
//   mem_valid_i      memory completion strobe, only honoured in BUSY
//   mem_data_i       memory read line
//
// Configuration
//   MEM_ARB_ROUND_ROBIN_EN  when defined, simultaneous requests alternate
//                           between the two caches (icache first after
//                           reset). When undefined, icache always wins a
//                           tie and no grant history is kept.
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_i,
  input  logic [ADDR_WIDTH-1:0] i_addr_i,
  output logic                  i_valid_o,
  output logic [LINE_WIDTH-1:0] i_data_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [LINE_WIDTH-1:0] d_wdata_i,
  output logic                  d_valid_o,
  output logic [LINE_WIDTH-1:0] d_data_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [LINE_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_valid_i,
  input  logic [LINE_WIDTH-1:0] mem_data_i
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY    = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  logic [1:0]            state_q;
  logic                  owner_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [LINE_WIDTH-1:0] wdata_q;

  logic                  any_req;
  logic                  winner;
  logic                  busy;
  logic                  done;

  assign any_req = i_req_i | d_req_i;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant_q;

  // On a tie the cache that was not granted last time wins; a lone
  // requester always wins regardless of history.
  always_comb begin
    winner = OWN_I;
    if (d_req_i && (!i_req_i || last_grant_q == OWN_I)) begin
      winner = OWN_D;
    end
  end

  // Grant history. Reset to dcache so the first tie goes to icache.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= OWN_D;
    end else if (state_q == S_IDLE && any_req) begin
      last_grant_q <= winner;
    end
  end
`else
  // Fixed priority: dcache only wins when icache is not asking.
  always_comb begin
    winner = OWN_I;
    if (d_req_i && !i_req_i) begin
      winner = OWN_D;
    end
  end
`endif

  // Main FSM plus the request latch. The latch is written only on the
  // IDLE->BUSY transition, so requester inputs can change freely during
  // BUSY without disturbing the transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= OWN_I;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            owner_q <= winner;
            if (winner == OWN_D) begin
              addr_q  <= d_addr_i;
              we_q    <= d_we_i;
              wdata_q <= d_wdata_i;
            end else begin
              addr_q  <= i_addr_i;
              we_q    <= 1'b0;
              wdata_q <= '0;
            end
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (mem_valid_i) begin
            state_q <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Everything below is decoded from state, so the asynchronous reset
  // of state_q forces all outputs low straight away.
  assign busy = (state_q == S_BUSY);
  assign done = busy & mem_valid_i;

  assign mem_req_o   = busy;
  assign mem_we_o    = busy & we_q;
  assign mem_addr_o  = busy ? addr_q  : '0;
  assign mem_wdata_o = busy ? wdata_q : '0;

  assign i_valid_o = done & (owner_q == OWN_I);
  assign d_valid_o = done & (owner_q == OWN_D);

  assign i_data_o = i_valid_o ? mem_data_i : '0;
  assign d_data_o = d_valid_o ? mem_data_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// ---------------------------------------------------------------------------
// Randomised scoreboard bench for mem_arbiter. Each round raises one or both
// cache requests; a reference model predicts the grant order and the data a
// simple line memory should return, pushing one expected response per grant.
// A monitor pops an entry whenever a response strobe appears. A small
// behavioural memory answers mem_req_o with a random latency.
// Build with MEM_ARB_ROUND_ROBIN_EN to check the round-robin variant.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  logic         clk;
  logic         rst_n;
  logic         i_req_i;
  logic [31:0]  i_addr_i;
  logic         i_valid_o;
  logic [127:0] i_data_o;
  logic         d_req_i;
  logic         d_we_i;
  logic [31:0]  d_addr_i;
  logic [127:0] d_wdata_i;
  logic         d_valid_o;
  logic [127:0] d_data_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_wdata_o;
  logic         mem_valid_i;
  logic [127:0] mem_data_i;

  mem_arbiter #(.ADDR_WIDTH(32), .LINE_WIDTH(128)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req_i    (i_req_i),
    .i_addr_i   (i_addr_i),
    .i_valid_o  (i_valid_o),
    .i_data_o   (i_data_o),
    .d_req_i    (d_req_i),
    .d_we_i     (d_we_i),
    .d_addr_i   (d_addr_i),
    .d_wdata_i  (d_wdata_i),
    .d_valid_o  (d_valid_o),
    .d_data_o   (d_data_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_valid_i(mem_valid_i),
    .mem_data_i (mem_data_i)
  );

  typedef struct {
    logic         port;   // 0 icache, 1 dcache
    logic [31:0]  addr;
    logic         we;
    logic [127:0] wdata;
    logic [127:0] rdata;
  } exp_t;

  exp_t         exp_q[$];
  logic [127:0] ref_mem [16];   // model's view of memory contents
  logic [127:0] mem_env [16];   // behavioural memory answering the DUT
  logic         model_last;     // model's record of the last grant
  int           checks = 0;
  int           passed = 0;
  int           i_seen = 0;
  int           d_seen = 0;

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // Reference model for one expected grant.
  task automatic pushI(input logic [31:0] a);
    exp_t e;
    e.port = 1'b0; e.addr = a; e.we = 1'b0; e.wdata = '0;
    e.rdata = ref_mem[a[7:4]];
    exp_q.push_back(e);
  endtask

  task automatic pushD(input logic we, input logic [31:0] a,
                       input logic [127:0] wd);
    exp_t e;
    e.port = 1'b1; e.addr = a; e.we = we; e.wdata = wd;
    if (we) begin
      ref_mem[a[7:4]] = wd;
      e.rdata = '0;
    end else begin
      e.rdata = ref_mem[a[7:4]];
    end
    exp_q.push_back(e);
  endtask

  // Raise requests (kind: 1 icache, 2 dcache, 3 both) and queue the
  // expected responses in the order the grant rule dictates.
  task automatic applyStimulus(input int kind, input logic [31:0] ia,
                               input logic dwe, input logic [31:0] da,
                               input logic [127:0] dwd);
    logic d_first;
    d_first = 1'b0;
    if (kind == 3) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      d_first = (model_last == 1'b0);
`endif
      if (d_first) begin
        pushD(dwe, da, dwd); pushI(ia); model_last = 1'b0;
      end else begin
        pushI(ia); pushD(dwe, da, dwd); model_last = 1'b1;
      end
    end else if (kind == 1) begin
      pushI(ia); model_last = 1'b0;
    end else begin
      pushD(dwe, da, dwd); model_last = 1'b1;
    end
    i_addr_i = ia; d_we_i = dwe; d_addr_i = da; d_wdata_i = dwd;
    i_req_i = (kind != 2);
    d_req_i = (kind != 1);
  endtask

  // Play memory and requesters until every outstanding request has been
  // answered. dly < 0 picks a random latency per transaction; hold keeps a
  // satisfied request high for extra cycles after its response.
  task automatic waitDone(input int dly, input int hold);
    int cyc = 0;
    int cnt = 0;
    int lat;
    int i_base = i_seen;
    int d_base = d_seen;
    int i_hold = 0;
    int d_hold = 0;
    lat = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
    while ((i_req_i || d_req_i || mem_valid_i) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (mem_valid_i) begin
        mem_valid_i = 1'b0;
        mem_data_i  = '0;
      end else if (mem_req_o) begin
        if (cnt >= lat) begin
          mem_valid_i = 1'b1;
          if (mem_we_o) begin
            mem_env[mem_addr_o[7:4]] = mem_wdata_o;
            mem_data_i = '0;
          end else begin
            mem_data_i = mem_env[mem_addr_o[7:4]];
          end
          cnt = 0;
          lat = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
        end else begin
          cnt++;
        end
      end
      if (i_req_i && i_seen > i_base) begin
        if (i_hold >= hold) i_req_i = 1'b0;
        else i_hold++;
      end
      if (d_req_i && d_seen > d_base) begin
        if (d_hold >= hold) d_req_i = 1'b0;
        else d_hold++;
      end
    end
    if (cyc >= 200) begin
      checkOutput("response_timeout", 1, 0);
      i_req_i = 1'b0; d_req_i = 1'b0; mem_valid_i = 1'b0;
    end
  endtask

  // Monitor: samples 1 time unit before each rising edge and scores every
  // response strobe against the head of the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (i_valid_o && d_valid_o) begin
        checkOutput("both_valid", 1, 0);
      end else if (i_valid_o || d_valid_o) begin
        if (i_valid_o) i_seen++;
        if (d_valid_o) d_seen++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_valid", {i_valid_o, d_valid_o}, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("resp_port", d_valid_o, e.port);
          checkOutput("resp_data", d_valid_o ? d_data_o : i_data_o, e.rdata);
          checkOutput("mem_addr", mem_addr_o, e.addr);
          checkOutput("mem_we", mem_we_o, e.we);
          checkOutput("mem_wdata", mem_wdata_o, e.wdata);
        end
      end
      if (mem_valid_i && !i_valid_o) checkOutput("i_data_idle_zero", i_data_o, 0);
      if (mem_valid_i && !d_valid_o) checkOutput("d_data_idle_zero", d_data_o, 0);
    end
  end

  // Directed cases first, then randomised rounds.
  initial begin
    logic [127:0] v;
    logic [31:0]  ia;
    logic [31:0]  da;
    int           kind;
    rst_n = 1'b0;
    i_req_i = 1'b0; i_addr_i = '0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
    mem_valid_i = 1'b0; mem_data_i = '0;
    model_last = 1'b1;
    for (int k = 0; k < 16; k++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      ref_mem[k] = v;
      mem_env[k] = v;
    end
    ref_mem[4] = {16{8'hA5}};
    mem_env[4] = {16{8'hA5}};

    // Outputs held low in reset even with live inputs.
    repeat (2) @(negedge clk);
    i_req_i = 1'b1; d_req_i = 1'b1; mem_valid_i = 1'b1; mem_data_i = '1;
    repeat (2) @(negedge clk);
    #4;
    checkOutput("rst_mem_req", mem_req_o, 0);
    checkOutput("rst_valids", {i_valid_o, d_valid_o}, 0);
    checkOutput("rst_mem_addr", mem_addr_o, 0);
    @(negedge clk);
    i_req_i = 1'b0; d_req_i = 1'b0; mem_valid_i = 1'b0; mem_data_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Icache read, memory answers two cycles after the request appears.
    applyStimulus(1, 32'h0000_1040, 1'b0, '0, '0);
    #4 checkOutput("idle_no_req_yet", mem_req_o, 0);
    waitDone(2, 0);
    repeat (2) @(negedge clk);

    // Dcache write, answered one cycle after the request appears.
    applyStimulus(2, '0, 1'b1, 32'h0000_2000, 128'h1234);
    waitDone(1, 0);
    @(negedge clk);

    // Requester keeps its request through the RELEASE cycle.
    applyStimulus(1, 32'h0000_0350, 1'b0, '0, '0);
    waitDone(-1, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #4 checkOutput("stale_no_regrant", mem_req_o, 0);
    end

    // Spurious memory strobe while idle.
    @(negedge clk);
    mem_valid_i = 1'b1; mem_data_i = '1;
    repeat (2) @(negedge clk);
    #1 checkOutput("spurious_no_valid", {i_valid_o, d_valid_o, mem_req_o}, 0);
    @(negedge clk);
    mem_valid_i = 1'b0; mem_data_i = '0;

    // Reset in the middle of a transaction, then a late memory strobe.
    @(negedge clk);
    i_addr_i = 32'h0000_0770; i_req_i = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("busy_before_reset", mem_req_o, 1);
    rst_n = 1'b0;
    #1 checkOutput("reset_async_mem_req", mem_req_o, 0);
    i_req_i = 1'b0;
    mem_valid_i = 1'b1; mem_data_i = '1;
    @(negedge clk);
    #4 checkOutput("reset_no_valid", {i_valid_o, d_valid_o}, 0);
    @(negedge clk);
    rst_n = 1'b1; mem_valid_i = 1'b0; mem_data_i = '0;
    model_last = 1'b1;
    @(negedge clk);
    #4 checkOutput("after_reset_idle", mem_req_o, 0);
    @(negedge clk);

    // Simultaneous requests straight after reset, twice.
    for (int r = 0; r < 2; r++) begin
      applyStimulus(3, 32'h0000_0100 + 32'(r * 16), 1'b0,
                    32'h0000_0900 + 32'(r * 32), '0);
      waitDone(-1, 0);
      @(negedge clk);
    end

    // Randomised rounds.
    for (int r = 0; r < 60; r++) begin
      kind = int'($urandom_range(1, 3));
      ia = ($urandom & 32'hFFFF_FF0F) | (32'($urandom_range(0, 15)) << 4);
      da = ($urandom & 32'hFFFF_FF0F) | (32'($urandom_range(0, 15)) << 4);
      v  = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(kind, ia, 1'($urandom), da, v);
      waitDone(-1, int'($urandom_range(0, 1)));
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 128'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
